// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_pkg : shared widths and requester-ID encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_write_arbiter_pkg;

   localparam int c_DATA_W = 32;
   localparam int c_ADDR_W = 5;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_id_e;

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if : requester handshakes and register-file write bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface regfile_write_arbiter_if
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_W = c_DATA_W,
   parameter int ADDR_W = c_ADDR_W,
   parameter int CNT_W  = 16
);

   logic              req0_valid;
   logic              req0_ready;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req1_valid;
   logic              req1_ready;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              writeEnable;
   logic [ADDR_W-1:0] writeAddr;
   logic [DATA_W-1:0] writeData;
   logic              grant_id;
   logic [CNT_W-1:0]  stall0_cnt;
   logic [CNT_W-1:0]  stall1_cnt;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready,
      output writeEnable, writeAddr, writeData, grant_id,
      output stall0_cnt, stall1_cnt
   );

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready,
      input  writeEnable, writeAddr, writeData, grant_id,
      input  stall0_cnt, stall1_cnt
   );

endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// ---------------------------------------------------------------------------
// wb_hold_buffer : single-entry writeback holder with accept/free and age flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_hold_buffer
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_W = c_DATA_W,
   parameter int ADDR_W = c_ADDR_W
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              accept,
   input  wire logic              free,
   input  wire logic              set_old,
   input  wire logic [ADDR_W-1:0] in_addr,
   input  wire logic [DATA_W-1:0] in_data,
   output logic                   valid,
   output logic [ADDR_W-1:0]      addr,
   output logic [DATA_W-1:0]      data,
   output logic                   old
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_old;

   // old means this entry was accepted before the other buffer's current entry
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_old   <= 1'b0;
      end else if (accept) begin
         r_valid <= 1'b1;
         r_addr  <= in_addr;
         r_data  <= in_data;
         r_old   <= 1'b0;
      end else if (free) begin
         r_valid <= 1'b0;
         r_old   <= 1'b0;
      end else if (set_old) begin
         r_old   <= 1'b1;
      end
   end

   assign valid = r_valid;
   assign addr  = r_addr;
   assign data  = r_data;
   assign old   = r_old;

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter : age/round-robin arbiter for the register-file write port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_W  = c_DATA_W,
   parameter int ADDR_W  = c_ADDR_W,
   parameter int DROP_R0 = 0,
   parameter int CNT_W   = 16
) (
   input  wire logic              clk,
   input  wire logic              rst,
   regfile_write_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              w_valid0, w_valid1;
   logic              w_old0, w_old1;
   logic [ADDR_W-1:0] w_addr0, w_addr1;
   logic [DATA_W-1:0] w_data0, w_data1;
   logic              w_tie, w_gnt0, w_gnt1;
   logic              w_ready0, w_ready1;
   logic              w_acc0, w_acc1;
   logic              w_issue;
   logic [ADDR_W-1:0] w_gnt_addr;
   logic [DATA_W-1:0] w_gnt_data;

   req_id_e           r_rr;
   req_id_e           r_gid;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_stall0, r_stall1;

   wb_hold_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf0 (
      .clk     (clk),
      .rst     (rst),
      .accept  (w_acc0),
      .free    (w_gnt0),
      .set_old (w_acc1 && w_valid0 && !w_gnt0),
      .in_addr (bus.req0_addr),
      .in_data (bus.req0_data),
      .valid   (w_valid0),
      .addr    (w_addr0),
      .data    (w_data0),
      .old     (w_old0)
   );

   wb_hold_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf1 (
      .clk     (clk),
      .rst     (rst),
      .accept  (w_acc1),
      .free    (w_gnt1),
      .set_old (w_acc0 && w_valid1 && !w_gnt1),
      .in_addr (bus.req1_addr),
      .in_data (bus.req1_data),
      .valid   (w_valid1),
      .addr    (w_addr1),
      .data    (w_data1),
      .old     (w_old1)
   );

   // Older entry wins so same-register writebacks retire in acceptance order
   always_comb begin
      w_tie  = w_valid0 && w_valid1 && (w_old0 == w_old1);
      w_gnt0 = w_valid0;
      if (w_valid0 && w_valid1) begin
         w_gnt0 = w_tie ? (r_rr == REQ_ALU) : w_old0;
      end
      w_gnt1     = w_valid1 && !w_gnt0;
      w_gnt_addr = w_gnt1 ? w_addr1 : w_addr0;
      w_gnt_data = w_gnt1 ? w_data1 : w_data0;
      w_issue    = (w_gnt0 || w_gnt1) && !((DROP_R0 != 0) && (w_gnt_addr == '0));
   end

   assign w_ready0 = !w_valid0 || w_gnt0;
   assign w_ready1 = !w_valid1 || w_gnt1;
   assign w_acc0   = bus.req0_valid && w_ready0;
   assign w_acc1   = bus.req1_valid && w_ready1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr     <= REQ_ALU;
         r_gid    <= REQ_ALU;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_stall0 <= '0;
         r_stall1 <= '0;
      end else begin
         r_we <= w_issue;
         if (w_issue) begin
            r_addr <= w_gnt_addr;
            r_data <= w_gnt_data;
            r_gid  <= w_gnt1 ? REQ_MEM : REQ_ALU;
         end
         if (w_tie) begin
            r_rr <= (r_rr == REQ_ALU) ? REQ_MEM : REQ_ALU;
         end
         if (bus.req0_valid && !w_ready0 && (r_stall0 != '1)) begin
            r_stall0 <= r_stall0 + c_CNT_ONE;
         end
         if (bus.req1_valid && !w_ready1 && (r_stall1 != '1)) begin
            r_stall1 <= r_stall1 + c_CNT_ONE;
         end
      end
   end

   assign bus.req0_ready  = w_ready0;
   assign bus.req1_ready  = w_ready1;
   assign bus.writeEnable = r_we;
   assign bus.writeAddr   = r_addr;
   assign bus.writeData   = r_data;
   assign bus.grant_id    = r_gid;
   assign bus.stall0_cnt  = r_stall0;
   assign bus.stall1_cnt  = r_stall1;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter : directed tables plus randomized model comparison
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_write_arbiter;
   import regfile_write_arbiter_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          v0 = 1'b0, v1 = 1'b0;
   logic [AW-1:0] a0 = '0, a1 = '0;
   logic [DW-1:0] d0 = '0, d1 = '0;

   regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) bus_a ();
   regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4))  bus_b ();

   assign bus_a.req0_valid = v0;
   assign bus_a.req0_addr  = a0;
   assign bus_a.req0_data  = d0;
   assign bus_a.req1_valid = v1;
   assign bus_a.req1_addr  = a1;
   assign bus_a.req1_data  = d1;
   assign bus_b.req0_valid = v0;
   assign bus_b.req0_addr  = a0;
   assign bus_b.req0_data  = d0;
   assign bus_b.req1_valid = v1;
   assign bus_b.req1_addr  = a1;
   assign bus_b.req1_data  = d1;

   regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DROP_R0(0), .CNT_W(16)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DROP_R0(1), .CNT_W(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: each slot remembers the cycle it was accepted in;
   // the earliest stamp wins, equal stamps fall back to the rr pointer.
   // Index k of output arrays: 0 = dut_a (no drop, 16-bit), 1 = dut_b (drop r0, 4-bit).
   typedef struct {
      bit            v;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            stamp;
   } slot_t;

   slot_t         m[2];
   bit            m_rr;
   int            now;
   int            m_g;
   bit            m_tie;
   bit            m_rdy[2];
   bit            m_we[2];
   logic [AW-1:0] m_addr[2];
   logic [DW-1:0] m_data[2];
   bit            m_gid[2];
   int            m_st[2][2];
   int            sat[2] = '{65535, 15};

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m[i].v     = 1'b0;
         m[i].a     = '0;
         m[i].d     = '0;
         m[i].stamp = 0;
         m_we[i]    = 1'b0;
         m_addr[i]  = '0;
         m_data[i]  = '0;
         m_gid[i]   = 1'b0;
         m_st[i][0] = 0;
         m_st[i][1] = 0;
      end
      m_rr = 1'b0;
   endfunction

   function automatic void model_pick();
      m_g   = -1;
      m_tie = 1'b0;
      if (m[0].v && m[1].v) begin
         if (m[0].stamp < m[1].stamp)      m_g = 0;
         else if (m[1].stamp < m[0].stamp) m_g = 1;
         else begin
            m_g   = m_rr ? 1 : 0;
            m_tie = 1'b1;
         end
      end else if (m[0].v) begin
         m_g = 0;
      end else if (m[1].v) begin
         m_g = 1;
      end
      for (int i = 0; i < 2; i++) m_rdy[i] = !m[i].v || (m_g == i);
   endfunction

   function automatic void model_edge();
      bit            iv[2];
      logic [AW-1:0] ia[2];
      logic [DW-1:0] id[2];
      iv = '{v0, v1};
      ia = '{a0, a1};
      id = '{d0, d1};
      if (rst) begin
         model_reset();
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_we[k] = 1'b0;
            if (m_g >= 0 && !(k == 1 && m[m_g].a == '0)) begin
               m_we[k]   = 1'b1;
               m_addr[k] = m[m_g].a;
               m_data[k] = m[m_g].d;
               m_gid[k]  = (m_g == 1);
            end
         end
         if (m_tie) m_rr = !m_rr;
         if (m_g >= 0) m[m_g].v = 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (iv[i] && m_rdy[i]) begin
               m[i].v     = 1'b1;
               m[i].a     = ia[i];
               m[i].d     = id[i];
               m[i].stamp = now;
            end else if (iv[i]) begin
               for (int k = 0; k < 2; k++)
                  if (m_st[k][i] < sat[k]) m_st[k][i]++;
            end
         end
      end
      now++;
   endfunction

   bit s_rdy0 = 1'b1, s_rdy1 = 1'b1, s_rdyb0 = 1'b1;

   task automatic check_outputs();
      chk("a_we",     64'(bus_a.writeEnable), 64'(m_we[0]));
      chk("a_addr",   64'(bus_a.writeAddr),   64'(m_addr[0]));
      chk("a_data",   64'(bus_a.writeData),   64'(m_data[0]));
      chk("a_gid",    64'(bus_a.grant_id),    64'(m_gid[0]));
      chk("a_stall0", 64'(bus_a.stall0_cnt),  64'(m_st[0][0]));
      chk("a_stall1", 64'(bus_a.stall1_cnt),  64'(m_st[0][1]));
      chk("b_we",     64'(bus_b.writeEnable), 64'(m_we[1]));
      chk("b_addr",   64'(bus_b.writeAddr),   64'(m_addr[1]));
      chk("b_data",   64'(bus_b.writeData),   64'(m_data[1]));
      chk("b_gid",    64'(bus_b.grant_id),    64'(m_gid[1]));
      chk("b_stall0", 64'(bus_b.stall0_cnt),  64'(m_st[1][0]));
      chk("b_stall1", 64'(bus_b.stall1_cnt),  64'(m_st[1][1]));
   endtask

   // One clock: drive at negedge, check readies, clock, check registered outputs
   task automatic step(input int r, input int cv0, input int ca0, input logic [DW-1:0] cd0,
                       input int cv1, input int ca1, input logic [DW-1:0] cd1, input int chk_rdy);
      rst = (r != 0);
      v0  = (cv0 != 0);
      a0  = AW'(ca0);
      d0  = cd0;
      v1  = (cv1 != 0);
      a1  = AW'(ca1);
      d1  = cd1;
      #1;
      model_pick();
      s_rdy0  = bus_a.req0_ready;
      s_rdy1  = bus_a.req1_ready;
      s_rdyb0 = bus_b.req0_ready;
      if (chk_rdy != 0) begin
         chk("a_ready0", 64'(bus_a.req0_ready), 64'(m_rdy[0]));
         chk("a_ready1", 64'(bus_a.req1_ready), 64'(m_rdy[1]));
         chk("b_ready0", 64'(bus_b.req0_ready), 64'(m_rdy[0]));
         chk("b_ready1", 64'(bus_b.req1_ready), 64'(m_rdy[1]));
      end
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   typedef struct {
      int            v0, a0;
      logic [DW-1:0] d0;
      int            v1, a1;
      logic [DW-1:0] d1;
      bit            rdy0, rdy1, we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            gid;
   } vec_t;

   function automatic vec_t mk(input int cv0, input int ca0, input int cd0,
                               input int cv1, input int ca1, input int cd1,
                               input int r0, input int r1, input int we,
                               input int ea, input int ed, input int eg);
      vec_t t;
      t.v0 = cv0;  t.a0 = ca0;  t.d0 = DW'(cd0);
      t.v1 = cv1;  t.a1 = ca1;  t.d1 = DW'(cd1);
      t.rdy0 = (r0 != 0);  t.rdy1 = (r1 != 0);  t.we = (we != 0);
      t.addr = AW'(ea);  t.data = DW'(ed);  t.gid = (eg != 0);
      return t;
   endfunction

   // Randomized traffic; a stalled requester keeps its request stable
   task automatic rnd_phase(input int n, input int force_valid, input int allow_rst);
      int            nv0, nv1, na0, na1, nr;
      logic [DW-1:0] nd0, nd1;
      for (int i = 0; i < n; i++) begin
         if (v0 && !s_rdy0) begin
            nv0 = 1;  na0 = int'(a0);  nd0 = d0;
         end else begin
            nv0 = (force_valid != 0) ? 1 : int'($urandom_range(0, 9) < 7);
            na0 = int'($urandom_range((force_valid != 0) ? 1 : 0, 31));
            nd0 = $urandom;
         end
         if (v1 && !s_rdy1) begin
            nv1 = 1;  na1 = int'(a1);  nd1 = d1;
         end else begin
            nv1 = (force_valid != 0) ? 1 : int'($urandom_range(0, 9) < 7);
            na1 = int'($urandom_range((force_valid != 0) ? 1 : 0, 31));
            nd1 = $urandom;
         end
         nr = (allow_rst != 0 && $urandom_range(0, 49) == 0) ? 1 : 0;
         step(nr, nv0, na0, nd0, nv1, na1, nd1, 1);
      end
   endtask

   vec_t tbl[$];

   initial begin
      int pulses, rdy_drops;
      logic [AW-1:0] last_addr;
      logic [DW-1:0] last_data;

      model_reset();
      now = 0;

      // Reset: fill both buffers, then reset with valids high
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 10, 32'h10, 1, 11, 32'h11, 1);
      for (int i = 0; i < 3; i++) step(1, 1, 12, 32'h12, 1, 13, 32'h13, 1);
      chk("rst_ready0", 64'(s_rdy0), 64'd1);
      chk("rst_ready1", 64'(s_rdy1), 64'd1);
      chk("rst_we",     64'(bus_a.writeEnable), 64'd0);
      chk("rst_addr",   64'(bus_a.writeAddr),   64'd0);
      chk("rst_data",   64'(bus_a.writeData),   64'd0);
      chk("rst_gid",    64'(bus_a.grant_id),    64'd0);
      chk("rst_stall0", 64'(bus_a.stall0_cnt),  64'd0);
      chk("rst_stall1", 64'(bus_a.stall1_cnt),  64'd0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      chk("post_rst_we_a", 64'(bus_a.writeEnable), 64'd0);
      chk("post_rst_we_b", 64'(bus_b.writeEnable), 64'd0);

      // Lone streaming r1..r8 on requester 0
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(1, k, 32'h100 + k, 0, 0, 0, 1, 1, (k > 1) ? 1 : 0, k - 1, 32'h100 + k - 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 8, 32'h108, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      // Simultaneous pairs: rr=0 issues r3 first, then rr=1 issues r4 first
      tbl.push_back(mk(1, 3, 32'hAAAA, 1, 4, 32'h5555, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,        1, 4, 32'h5555, 1, 0, 1, 3, 32'hAAAA, 0));
      tbl.push_back(mk(1, 3, 32'hAAAA, 1, 4, 32'h5555, 1, 1, 1, 4, 32'h5555, 1));
      tbl.push_back(mk(1, 6, 32'h1234, 0, 0, 0,        0, 1, 1, 4, 32'h5555, 1));
      tbl.push_back(mk(1, 6, 32'h1234, 0, 0, 0,        1, 1, 1, 3, 32'hAAAA, 0));
      tbl.push_back(mk(0, 0, 0,        0, 0, 0,        1, 1, 1, 6, 32'h1234, 0));
      tbl.push_back(mk(0, 0, 0,        0, 0, 0,        1, 1, 0, 0, 0, 0));
      // Age ordering: older entry beats rr, r5<-1 retires before r5<-2
      tbl.push_back(mk(1, 7, 9, 1, 8, 3, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 9, 4, 0, 0, 0, 1, 0, 1, 7, 9, 0));
      tbl.push_back(mk(0, 0, 0, 1, 5, 1, 0, 1, 1, 8, 3, 1));
      tbl.push_back(mk(1, 5, 2, 0, 0, 0, 1, 0, 1, 9, 4, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 2, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(0, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, 1);
         chk($sformatf("tbl%0d_ready0", i), 64'(s_rdy0), 64'(tbl[i].rdy0));
         chk($sformatf("tbl%0d_ready1", i), 64'(s_rdy1), 64'(tbl[i].rdy1));
         chk($sformatf("tbl%0d_we", i), 64'(bus_a.writeEnable), 64'(tbl[i].we));
         if (tbl[i].we) begin
            chk($sformatf("tbl%0d_addr", i), 64'(bus_a.writeAddr), 64'(tbl[i].addr));
            chk($sformatf("tbl%0d_data", i), 64'(bus_a.writeData), 64'(tbl[i].data));
            chk($sformatf("tbl%0d_gid", i),  64'(bus_a.grant_id),  64'(tbl[i].gid));
         end
         if (i == 9) chk("stream_stall0", 64'(bus_a.stall0_cnt), 64'd0);
      end
      chk("pair_stall0", 64'(bus_a.stall0_cnt), 64'd1);
      chk("pair_stall1", 64'(bus_a.stall1_cnt), 64'd1);

      // Drop of register 0 on dut_b
      pulses    = 0;
      rdy_drops = 0;
      last_addr = '0;
      last_data = '0;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0:       step(0, 1, 0, 32'hFFFF, 0, 0, 0, 1);
            1:       step(0, 1, 2, 32'h7,    0, 0, 0, 1);
            default: step(0, 0, 0, 0,        0, 0, 0, 1);
         endcase
         if (!s_rdyb0) rdy_drops++;
         if (bus_b.writeEnable) begin
            pulses++;
            last_addr = bus_b.writeAddr;
            last_data = bus_b.writeData;
         end
      end
      chk("drop_pulses",    64'(pulses),    64'd1);
      chk("drop_addr",      64'(last_addr), 64'd2);
      chk("drop_data",      64'(last_data), 64'd7);
      chk("drop_rdy_drops", 64'(rdy_drops), 64'd0);

      // Both requesters streaming: 4-bit counters must pin at 15
      rnd_phase(60, 1, 0);
      chk("sat_stall1_b", 64'(bus_b.stall1_cnt), 64'd15);
      chk("sat_stall0_b", 64'(bus_b.stall0_cnt), 64'd15);

      rnd_phase(400, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
